mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single CPU-side port of the unified instruction/data distributed memory between two requesters.
- Requester 0 is the multicycle CPU datapath: fetch and lw/sw.
- Requester 1 is the debug/loader unit: program load, memory inspect and patch while stepping.
- The block sequences every access through a small FSM, applies CPU-first priority with a starvation bound for debug, and returns registered read data. It sits between the CPU/debug units and the memory instance.

Parameters:
- AW, 8: word-address width (memory depth 2^AW words).
- DW, 32: data width.
- STARVE_MAX, 4: consecutive CPU grants allowed while dbg_req is pending before debug is forced to win.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- cpu_req  in  1  CPU access request, level.
- cpu_we  in  1  1=write, 0=read.
- cpu_addr  in  AW  word address.
- cpu_wdata  in  DW  write data.
- cpu_gnt  out  1  access performed this cycle.
- cpu_rvalid  out  1  read data valid, one-cycle pulse.
- cpu_rdata  out  DW  read data.
- cpu_stall  out  1  cpu_req & ~cpu_gnt; the control unit holds its state while this is high.
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_gnt, dbg_rvalid, dbg_rdata: same meaning as the cpu_* ports, for the debug requester.
- dbg_lock  in  1  while 1, the CPU is never granted.
- mem_a  out  AW  memory address.
- mem_d  out  DW  memory write data.
- mem_we  out  1  memory write enable.
- mem_spo  in  DW  memory combinational read data.
- busy  out  1  FSM not in IDLE.

Behaviour:
- FSM states: IDLE, GNT_CPU, GNT_DBG.
- IDLE transitions, on the rising edge:
  - cpu_eff = cpu_req & ~dbg_lock.
  - If dbg_req and (starve_cnt == STARVE_MAX or ~cpu_eff), go to GNT_DBG.
  - Else if cpu_eff, go to GNT_CPU.
  - Else stay in IDLE.
- GNT_x lasts exactly one cycle, then always returns to IDLE. An access therefore takes 2 cycles (arbitrate, then perform), and maximum throughput is one access per 2 cycles.
- In GNT_x:
  - x_gnt = 1.
  - mem_a = x_addr, mem_d = x_wdata, mem_we = x_we. The memory commits the write at the end of this cycle.
- Outside GNT states: mem_we = 0, mem_a = 0, mem_d = 0.
- Read path: if GNT_x and ~x_we, x_rdata <= mem_spo at the end of the GNT cycle, and x_rvalid = 1 in the following cycle only.
  - Read latency from the gnt cycle is 1 cycle.
  - x_rdata holds its value until the next read for that requester.
- Handshake rules:
  - A requester holds req/we/addr/wdata stable from assertion until it samples gnt=1.
  - It may present a new request on the cycle after gnt.
  - A req dropped before gnt is a protocol error. The arbiter does not latch requests; if req is low in IDLE, nothing is selected.
- starve_cnt, width clog2(STARVE_MAX+1):
  - Increments (saturating) on each CPU grant while dbg_req = 1.
  - Clears on a debug grant or whenever dbg_req = 0.
- Simultaneous requests with starve_cnt < STARVE_MAX: the CPU wins.
- dbg_lock:
  - Rising while in GNT_CPU: the current CPU access completes and no further CPU grants are issued.
  - While locked, cpu_stall = cpu_req.
- Write and read to the same address in consecutive grants: the read returns the new data, because the write commits before the read's GNT cycle.
- Reset (rst = 0, asynchronous):
  - State goes to IDLE, starve_cnt to 0.
  - All gnt and rvalid outputs go to 0, mem_we to 0 immediately (combinationally gated by rst), so an in-flight write is aborted.
  - cpu_rdata and dbg_rdata go to 0; busy goes to 0.
- Reset release: the first arbitration happens on the first rising edge with rst = 1.

Decomposition:
- Package mem_arb_pkg holds:
  - the state encoding (IDLE=2'd0, GNT_CPU=2'd1, GNT_DBG=2'd2);
  - requester index constants (REQ_CPU=0, REQ_DBG=1);
  - a default STARVE_MAX.
- One natural sub-module, arb_starve_cnt: the saturating starvation counter with clear/increment inputs and an at_max output.
- The FSM, output muxing and read-data registers stay in the top.

Test Plan:
- CPU read only: addr=8'h04, mem holds 32'h2008_0005 → cpu_gnt in cycle 2; cpu_rvalid=1 in cycle 3 with cpu_rdata=32'h2008_0005; dbg outputs stay 0.
- Debug write then CPU read of the same address: dbg writes 32'hDEAD_BEEF to 8'h10, then the CPU reads 8'h10 → the CPU returns 32'hDEAD_BEEF; mem_we is high for exactly 1 cycle.
- Both requesting continuously, STARVE_MAX=4 → grant order CPU, CPU, CPU, CPU, DBG, repeating; starve_cnt never exceeds 4.
- dbg_lock=1 with both requesting → only dbg grants; cpu_stall stays 1 throughout; after dbg_lock drops, the CPU is granted within 2 cycles.
- rst pulsed low during a GNT_DBG write to 8'h20 → mem_we drops immediately; the address is unchanged; the FSM is in IDLE and busy=0 after release.
- Idle bus: no requests for 10 cycles → busy=0, mem_we=0, no gnt or rvalid pulses.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the CPU/debug memory port arbiter.
// State encoding, requester indices and the default starvation bound live here.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_CPU = 2'd1,
        GNT_DBG = 2'd2
    } arb_state_e;

    localparam int REQ_CPU        = 0;
    localparam int REQ_DBG        = 1;
    localparam int NUM_REQ        = 2;
    localparam int DEF_STARVE_MAX = 4;

    // Counter width able to hold 0..max inclusive.
    function automatic int cnt_width(input int max);
        return (max < 1) ? 1 : $clog2(max + 1);
    endfunction

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating count of CPU grants issued while debug is waiting.
// Clear has priority over increment; at_max_o forces the next debug win.
module arb_starve_cnt
    import mem_arb_pkg::*;
#(
    parameter int MAX = DEF_STARVE_MAX
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic inc_i,
    output logic at_max_o
);

    localparam int W = cnt_width(MAX);
    localparam logic [W-1:0] MAX_W = W'(MAX);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != MAX_W)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_max_o = (cnt_q == MAX_W);

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the single CPU-side port of the unified memory.
// Each access is arbitrate-then-perform; read data is registered per requester.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW         = 8,
    parameter int DW         = 32,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_gnt,
    output logic          dbg_rvalid,
    output logic [DW-1:0] dbg_rdata,
    input  logic          dbg_lock,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_d,
    output logic          mem_we,
    input  logic [DW-1:0] mem_spo,
    output logic          busy
);

    arb_state_e state_q;

    logic               cpu_eff;
    logic               starve_at_max;
    logic               mem_we_raw;
    logic [NUM_REQ-1:0] req_we;
    logic [NUM_REQ-1:0] gnt;
    logic [NUM_REQ-1:0] rvalid;
    logic [AW-1:0]      req_addr  [NUM_REQ];
    logic [DW-1:0]      req_wdata [NUM_REQ];
    logic [DW-1:0]      rdata     [NUM_REQ];

    assign req_we[REQ_CPU]    = cpu_we;
    assign req_we[REQ_DBG]    = dbg_we;
    assign req_addr[REQ_CPU]  = cpu_addr;
    assign req_addr[REQ_DBG]  = dbg_addr;
    assign req_wdata[REQ_CPU] = cpu_wdata;
    assign req_wdata[REQ_DBG] = dbg_wdata;

    assign cpu_eff = cpu_req & ~dbg_lock;

    // A grant is just the state register; rst gating kills it the instant reset asserts.
    assign gnt[REQ_CPU] = rst & (state_q == GNT_CPU);
    assign gnt[REQ_DBG] = rst & (state_q == GNT_DBG);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (dbg_req && (starve_at_max || !cpu_eff)) begin
                        state_q <= GNT_DBG;
                    end else if (cpu_eff) begin
                        state_q <= GNT_CPU;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    arb_starve_cnt #(
        .MAX(STARVE_MAX)
    ) u_starve (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (gnt[REQ_DBG] | ~dbg_req),
        .inc_i    (gnt[REQ_CPU] & dbg_req),
        .at_max_o (starve_at_max)
    );

    always_comb begin
        mem_a      = '0;
        mem_d      = '0;
        mem_we_raw = 1'b0;
        case (state_q)
            GNT_CPU: begin
                mem_a      = req_addr[REQ_CPU];
                mem_d      = req_wdata[REQ_CPU];
                mem_we_raw = req_we[REQ_CPU];
            end
            GNT_DBG: begin
                mem_a      = req_addr[REQ_DBG];
                mem_d      = req_wdata[REQ_DBG];
                mem_we_raw = req_we[REQ_DBG];
            end
            default: ;
        endcase
    end

    // Gated so a write already on the bus is aborted as soon as reset asserts.
    assign mem_we = mem_we_raw & rst;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rd
        logic          rd_fire;
        logic          rvalid_q;
        logic [DW-1:0] rdata_q;

        assign rd_fire = gnt[gi] & ~req_we[gi];

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                rvalid_q <= 1'b0;
                rdata_q  <= '0;
            end else begin
                rvalid_q <= rd_fire;
                if (rd_fire) begin
                    rdata_q <= mem_spo;
                end
            end
        end

        assign rvalid[gi] = rvalid_q;
        assign rdata[gi]  = rdata_q;
    end

    assign cpu_gnt    = gnt[REQ_CPU];
    assign dbg_gnt    = gnt[REQ_DBG];
    assign cpu_rvalid = rvalid[REQ_CPU];
    assign dbg_rvalid = rvalid[REQ_DBG];
    assign cpu_rdata  = rdata[REQ_CPU];
    assign dbg_rdata  = rdata[REQ_DBG];
    assign cpu_stall  = cpu_req & ~cpu_gnt;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural distributed memory attached.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mem_port_arbiter;

    localparam int AW = 8;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_gnt, cpu_rvalid, cpu_stall;
    logic [DW-1:0] cpu_rdata;
    logic          dbg_req = 1'b0, dbg_we = 1'b0, dbg_lock = 1'b0;
    logic [AW-1:0] dbg_addr = '0;
    logic [DW-1:0] dbg_wdata = '0;
    logic          dbg_gnt, dbg_rvalid;
    logic [DW-1:0] dbg_rdata;
    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_d;
    logic          mem_we;
    logic [DW-1:0] mem_spo;
    logic          busy;

    logic [DW-1:0] tb_mem [2**AW];
    int            checks = 0;
    int            errors = 0;
    int            we_hi  = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .dbg_req    (dbg_req),
        .dbg_we     (dbg_we),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .dbg_gnt    (dbg_gnt),
        .dbg_rvalid (dbg_rvalid),
        .dbg_rdata  (dbg_rdata),
        .dbg_lock   (dbg_lock),
        .mem_a      (mem_a),
        .mem_d      (mem_d),
        .mem_we     (mem_we),
        .mem_spo    (mem_spo),
        .busy       (busy)
    );

    assign mem_spo = tb_mem[mem_a];

    always @(posedge clk) begin
        if (mem_we) tb_mem[mem_a] <= mem_d;
    end

    always @(negedge clk) begin
        if (mem_we) we_hi++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    // One complete access from an idle arbiter: request, grant, then read return.
    task automatic do_access(input int who, input logic we, input logic [7:0] addr,
                             input logic [31:0] wd, input logic [31:0] exp_rd, input string tag);
        int   lat;
        logic seen;
        if (who == 0) begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        end else begin
            dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wd;
        end
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 20) begin
            @(negedge clk);
            lat++;
            seen = (who == 0) ? cpu_gnt : dbg_gnt;
        end
        check_eq({tag, "_gnt_lat"}, 32'(lat), 32'd1);
        check_eq({tag, "_mem_a"}, 32'(mem_a), 32'(addr));
        check_eq({tag, "_mem_we"}, 32'(mem_we), 32'(we));
        check_eq({tag, "_other_gnt"}, 32'((who == 0) ? dbg_gnt : cpu_gnt), 32'd0);
        if (who == 0) cpu_req = 1'b0; else dbg_req = 1'b0;
        @(negedge clk);
        check_eq({tag, "_rvalid"}, 32'((who == 0) ? cpu_rvalid : dbg_rvalid), 32'(!we));
        check_eq({tag, "_other_rvalid"}, 32'((who == 0) ? dbg_rvalid : cpu_rvalid), 32'd0);
        if (!we) check_eq({tag, "_rdata"}, (who == 0) ? cpu_rdata : dbg_rdata, exp_rd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int           n, both, stall_bad, cgnt, dgnt, lat, act;
        logic [9:0]   seq;

        for (int i = 0; i < 2**AW; i++) tb_mem[i] = 32'(i);
        tb_mem[8'h04] = 32'h2008_0005;
        tb_mem[8'h20] = 32'h1111_1111;

        #1;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_mem_we", 32'(mem_we), 32'd0);
        check_eq("rst_gnts", 32'({cpu_gnt, dbg_gnt}), 32'd0);
        check_eq("rst_rvalids", 32'({cpu_rvalid, dbg_rvalid}), 32'd0);
        check_eq("rst_cpu_rdata", cpu_rdata, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        do_access(0, 1'b0, 8'h04, 32'd0, 32'h2008_0005, "cpu_rd04");

        we_hi = 0;
        do_access(1, 1'b1, 8'h10, 32'hDEAD_BEEF, 32'd0, "dbg_wr10");
        check_eq("dbg_wr10_we_cycles", 32'(we_hi), 32'd1);
        do_access(0, 1'b0, 8'h10, 32'd0, 32'hDEAD_BEEF, "cpu_rd10");
        do_access(1, 1'b0, 8'h04, 32'd0, 32'h2008_0005, "dbg_rd04");

        // Both requesting back to back: four CPU grants then one debug grant.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h04;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'h10;
        seq = '0; n = 0; both = 0; stall_bad = 0;
        for (int c = 0; c < 40 && n < 10; c++) begin
            @(negedge clk);
            if (cpu_gnt && dbg_gnt) both++;
            if (cpu_stall !== (cpu_req & ~cpu_gnt)) stall_bad++;
            if (dbg_gnt) seq[n] = 1'b1;
            if (cpu_gnt || dbg_gnt) n++;
        end
        cpu_req = 1'b0; dbg_req = 1'b0;
        check_eq("fair_grant_count", 32'(n), 32'd10);
        check_eq("fair_grant_order", 32'(seq), 32'(10'b10000_10000));
        check_eq("fair_no_double_gnt", 32'(both), 32'd0);
        check_eq("fair_stall", 32'(stall_bad), 32'd0);
        @(negedge clk);
        @(negedge clk);

        dbg_lock = 1'b1;
        cpu_req = 1'b1; dbg_req = 1'b1;
        cgnt = 0; dgnt = 0; stall_bad = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (cpu_gnt) cgnt++;
            if (dbg_gnt) dgnt++;
            if (cpu_stall !== 1'b1) stall_bad++;
        end
        check_eq("lock_cpu_gnts", 32'(cgnt), 32'd0);
        check_eq("lock_dbg_gnts", 32'(dgnt), 32'd6);
        check_eq("lock_stall_high", 32'(stall_bad), 32'd0);
        dbg_lock = 1'b0;
        lat = 0;
        while (lat < 6) begin
            @(negedge clk);
            lat++;
            if (cpu_gnt) break;
        end
        check_eq("unlock_cpu_within_2", 32'(lat <= 2), 32'd1);
        cpu_req = 1'b0; dbg_req = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Reset asserted in the middle of a debug write to 8'h20.
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h20; dbg_wdata = 32'hCAFE_F00D;
        @(negedge clk);
        check_eq("rstwr_gnt", 32'(dbg_gnt), 32'd1);
        check_eq("rstwr_we_before", 32'(mem_we), 32'd1);
        #1 rst = 1'b0;
        #1;
        check_eq("rstwr_we_dropped", 32'(mem_we), 32'd0);
        check_eq("rstwr_gnt_dropped", 32'(dbg_gnt), 32'd0);
        check_eq("rstwr_busy", 32'(busy), 32'd0);
        dbg_req = 1'b0; dbg_we = 1'b0;
        @(negedge clk);
        check_eq("rstwr_mem_unchanged", tb_mem[8'h20], 32'h1111_1111);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rstrel_busy", 32'(busy), 32'd0);
        check_eq("rstrel_cpu_rdata", cpu_rdata, 32'd0);
        check_eq("rstrel_dbg_rdata", dbg_rdata, 32'd0);

        act = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (busy || mem_we || cpu_gnt || dbg_gnt || cpu_rvalid || dbg_rvalid) act++;
        end
        check_eq("idle_activity", 32'(act), 32'd0);

        do_access(1, 1'b0, 8'h20, 32'd0, 32'h1111_1111, "dbg_rd20");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
